// File: rtl/synapse_access_ctrl.sv
// -----------------------------------------------------------------------------
// synapse_access_ctrl
//
// Single-port access controller for the synapse weight memory (WORDS x 32 bit,
// four 8-bit weights per word, byte k of word w holds byte address 4*w+k).
// After reset (or kill) it streams the initial weight table into memory, then
// arbitrates spike-driven weight reads against STDP read-modify-write updates.
// Reads win by default; an STDP request that has been passed over STARVE_LIM
// times in a row takes priority. The memory macro has 1-cycle read latency.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   kill              synchronous restart into the table load
//   init_valid/ready  init word handshake, init_data is the word being loaded
//   init_done         table loaded, arbitration enabled (registered)
//   rd_req/rd_addr    weight read request (byte address), rd_ack accepts it
//   rd_valid/weight   read result, one cycle after rd_ack
//   stdp_req/addr     STDP update request (byte address) with signed delta,
//   stdp_delta        stdp_ack accepts it
//   mem_*             memory port: enable, write enable, word address,
//                     write data, read data (valid the cycle after a read)
// -----------------------------------------------------------------------------
module synapse_access_ctrl #(
  parameter int unsigned WORDS      = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kill,
  input  logic        init_valid,
  input  logic [31:0] init_data,
  output logic        init_ready,
  output logic        init_done,
  input  logic        rd_req,
  input  logic [6:0]  rd_addr,
  output logic        rd_ack,
  output logic        rd_valid,
  output logic [7:0]  rd_weight,
  input  logic        stdp_req,
  input  logic [6:0]  stdp_addr,
  input  logic [8:0]  stdp_delta,
  output logic        stdp_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [4:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW = 5;
  localparam int unsigned WW = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_STDP_WR} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        init_cnt_q, init_cnt_d;
  logic                 init_done_q, init_done_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic                 rd_valid_q;
  logic [1:0]           rd_sel_q;
  logic [AW-1:0]        upd_word_q;
  logic [1:0]           upd_sel_q;
  logic signed [8:0]    upd_delta_q;

  logic                 stdp_win;
  logic [7:0]           upd_old;
  logic signed [9:0]    upd_sum;
  logic [31:0]          upd_word;

  // Clamp a 10-bit signed sum into the unsigned 8-bit weight range.
  function automatic logic [7:0] sat_u8(input logic signed [9:0] s);
    if (s < 10'sd0)
      return 8'd0;
    else if (s > 10'sd255)
      return 8'hFF;
    else
      return s[7:0];
  endfunction

  // Read-modify-write datapath: mem_rdata carries the word read at the grant.
  always_comb begin
    upd_old  = mem_rdata[{upd_sel_q, 3'b000} +: 8];
    upd_sum  = $signed({2'b00, upd_old}) + $signed({upd_delta_q[8], upd_delta_q});
    upd_word = mem_rdata;
    upd_word[{upd_sel_q, 3'b000} +: 8] = sat_u8(upd_sum);
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    wait_d      = wait_q;
    init_ready  = 1'b0;
    rd_ack      = 1'b0;
    stdp_ack    = 1'b0;
    stdp_win    = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (kill) begin
      // Port stays quiet so a pending STDP write is dropped.
      state_d     = S_INIT;
      init_cnt_d  = '0;
      init_done_d = 1'b0;
      wait_d      = '0;
    end else begin
      case (state_q)
        S_INIT: begin
          init_ready = 1'b1;
          if (init_valid) begin
            mem_en     = 1'b1;
            mem_we     = 1'b1;
            mem_addr   = init_cnt_q;
            mem_wdata  = init_data;
            init_cnt_d = init_cnt_q + AW'(1);
            if (init_cnt_q == AW'(WORDS - 1)) begin
              state_d     = S_IDLE;
              init_done_d = 1'b1;
            end
          end
          if (!stdp_req) wait_d = '0;
        end
        S_IDLE: begin
          stdp_win = stdp_req && (!rd_req || wait_q == WW'(STARVE_LIM));
          if (stdp_win) begin
            stdp_ack = 1'b1;
            mem_en   = 1'b1;
            mem_addr = stdp_addr[6:2];
            state_d  = S_STDP_WR;
          end else if (rd_req) begin
            rd_ack   = 1'b1;
            mem_en   = 1'b1;
            mem_addr = rd_addr[6:2];
          end
          if (!stdp_req || stdp_win)
            wait_d = '0;
          else if (wait_q != WW'(STARVE_LIM))
            wait_d = wait_q + WW'(1);
        end
        S_STDP_WR: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = upd_word_q;
          mem_wdata = upd_word;
          state_d   = S_IDLE;
          if (!stdp_req) wait_d = '0;
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  // Control state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      wait_q      <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      wait_q      <= wait_d;
      rd_valid_q  <= rd_ack;
    end
  end

  // Request capture: byte selects and the update operands
  always_ff @(posedge clk) begin
    if (rd_ack)
      rd_sel_q <= rd_addr[1:0];
    if (stdp_ack) begin
      upd_word_q  <= stdp_addr[6:2];
      upd_sel_q   <= stdp_addr[1:0];
      upd_delta_q <= $signed(stdp_delta);
    end
  end

  // The macro returns data in the cycle after the read, so the weight is
  // steered from the registered byte select and forced to 0 when not valid.
  always_comb begin
    rd_weight = 8'd0;
    if (rd_valid_q)
      rd_weight = mem_rdata[{rd_sel_q, 3'b000} +: 8];
  end

  assign rd_valid  = rd_valid_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_synapse_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_synapse_access_ctrl
//
// Directed bench for synapse_access_ctrl with a behavioural 1-cycle-latency
// weight memory. Expected read weights are queued when a read is issued and a
// monitor compares them whenever rd_valid is presented.
// -----------------------------------------------------------------------------
module tb_synapse_access_ctrl;

  localparam int WORDS = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        kill = 1'b0;
  logic        init_valid = 1'b0;
  logic [31:0] init_data = '0;
  logic        init_ready, init_done;
  logic        rd_req = 1'b0;
  logic [6:0]  rd_addr = '0;
  logic        rd_ack, rd_valid;
  logic [7:0]  rd_weight;
  logic        stdp_req = 1'b0;
  logic [6:0]  stdp_addr = '0;
  logic [8:0]  stdp_delta = '0;
  logic        stdp_ack;
  logic        mem_en, mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem   [WORDS];
  logic [31:0] model [WORDS];
  logic [7:0]  exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  synapse_access_ctrl #(.WORDS(32), .STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst), .kill(kill),
    .init_valid(init_valid), .init_data(init_data), .init_ready(init_ready),
    .init_done(init_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_weight(rd_weight),
    .stdp_req(stdp_req), .stdp_addr(stdp_addr), .stdp_delta(stdp_delta),
    .stdp_ack(stdp_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Weight memory macro, read data registered one cycle after the access
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Read-data monitor
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rd_unexpected: got %0h expected no read data at %0t", rd_weight, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rd_weight", rd_weight, e);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic init_load();
    logic [31:0] w;
    for (int i = 0; i < WORDS; i++) begin
      if (i == 10) begin
        @(negedge clk);
        init_valid = 1'b0;
        #1;
        chk("init_gap_en", mem_en, 0);
        chk("init_gap_rdy", init_ready, 1);
      end
      @(negedge clk);
      w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      model[i]   = w;
      init_valid = 1'b1;
      init_data  = w;
      rd_req     = (i < 3) ? 1'b1 : 1'b0;
      stdp_req   = (i < 3) ? 1'b1 : 1'b0;
      rd_addr    = 7'h05;
      stdp_addr  = 7'h05;
      stdp_delta = 9'd1;
      #1;
      chk("init_en_we", {mem_en, mem_we}, 2'b11);
      chk("init_addr", mem_addr, i[4:0]);
      chk("init_wdata", mem_wdata, w);
      chk("init_rdy", init_ready, 1);
      chk("init_done_early", init_done, 0);
      if (i < 3) chk("init_no_ack", {rd_ack, stdp_ack}, 0);
    end
    @(negedge clk);
    init_valid = 1'b0;
    rd_req     = 1'b0;
    stdp_req   = 1'b0;
    #1;
    chk("init_done", init_done, 1);
    chk("init_rdy_off", init_ready, 0);
  endtask

  task automatic rd(input logic [6:0] a, input logic [7:0] exp);
    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = a;
    #1;
    chk("rd_ack", rd_ack, 1);
    chk("rd_port", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, a[6:2]});
    exp_q.push_back(exp);
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    chk("rd_latency", rd_valid, 1);
  endtask

  task automatic upd(input logic [6:0] a, input logic [8:0] d, input logic [7:0] exp_new);
    logic [31:0] w;
    @(negedge clk);
    stdp_req   = 1'b1;
    stdp_addr  = a;
    stdp_delta = d;
    #1;
    chk("stdp_ack", stdp_ack, 1);
    chk("stdp_rd_port", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, a[6:2]});
    @(negedge clk);
    stdp_req = 1'b0;
    #1;
    w = model[a[6:2]];
    w[8*a[1:0] +: 8] = exp_new;
    model[a[6:2]] = w;
    chk("stdp_wr_port", {mem_en, mem_we, mem_addr}, {1'b1, 1'b1, a[6:2]});
    chk("stdp_wdata", mem_wdata, w);
    chk("stdp_wr_noack", {rd_ack, stdp_ack}, 0);
  endtask

  initial begin : stim
    logic [31:0] w;
    #1;
    chk("rst_init_ready", init_ready, 1);
    chk("rst_outs", {init_done, rd_valid, rd_weight, rd_ack, stdp_ack, mem_en, mem_we}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    init_load();
    rd(7'h45, 8'h45);

    // Saturating updates and untouched neighbours
    upd(7'd9, 9'd241, 8'd250);
    rd(7'd9, 8'd250);
    upd(7'd9, 9'd10, 8'd255);
    rd(7'd9, 8'd255);
    rd(7'd8, 8'd8);
    rd(7'd10, 8'd10);
    rd(7'd11, 8'd11);
    upd(7'd3, 9'h1F6, 8'd0);
    rd(7'd3, 8'd0);
    rd(7'd2, 8'd2);
    upd(7'd100, 9'h100, 8'd0);
    rd(7'd100, 8'd0);
    rd(7'd101, 8'd101);
    upd(7'd120, 9'd255, 8'd255);
    rd(7'd120, 8'd255);
    upd(7'd50, 9'h1FB, 8'd45);
    rd(7'd50, 8'd45);

    // Collision: reads win four times, then the starving update is granted
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        rd_req = 1'b1; rd_addr = 7'h30;
        stdp_req = 1'b1; stdp_addr = 7'h31; stdp_delta = 9'd2;
      end
      #1;
      chk("col_rd_ack", rd_ack, 1);
      chk("col_stdp_wait", stdp_ack, 0);
      exp_q.push_back(8'h30);
    end
    @(negedge clk);
    #1;
    chk("col_rd_held", rd_ack, 0);
    chk("col_stdp_ack", stdp_ack, 1);
    chk("col_stdp_port", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 5'd12});
    @(negedge clk);
    stdp_req = 1'b0;
    #1;
    w = model[12]; w[15:8] = 8'd51; model[12] = w;
    chk("col_wr_noack", {rd_ack, stdp_ack}, 0);
    chk("col_wr_port", {mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 5'd12});
    chk("col_wdata", mem_wdata, w);
    @(negedge clk);
    #1;
    chk("col_rd_resume", rd_ack, 1);
    exp_q.push_back(8'h30);
    @(negedge clk);
    rd_addr = 7'h31;
    #1;
    chk("col_rd_upd", rd_ack, 1);
    exp_q.push_back(8'd51);
    @(negedge clk);
    rd_req = 1'b0;

    // Read-after-update on the same weight
    @(negedge clk);
    stdp_req = 1'b1; stdp_addr = 7'd20; stdp_delta = 9'd1;
    #1;
    chk("rau_stdp_ack", stdp_ack, 1);
    @(negedge clk);
    stdp_req = 1'b0; rd_req = 1'b1; rd_addr = 7'd20;
    #1;
    chk("rau_no_rd_t1", rd_ack, 0);
    chk("rau_we", mem_we, 1);
    @(negedge clk);
    #1;
    chk("rau_rd_t2", rd_ack, 1);
    exp_q.push_back(8'd21);
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    chk("rau_valid", rd_valid, 1);

    // Kill during the STDP write
    @(negedge clk);
    stdp_req = 1'b1; stdp_addr = 7'd40; stdp_delta = 9'd5;
    #1;
    chk("kill_stdp_ack", stdp_ack, 1);
    @(negedge clk);
    stdp_req = 1'b0; kill = 1'b1; rd_req = 1'b1; rd_addr = 7'd0;
    #1;
    chk("kill_no_write", mem_en, 0);
    chk("kill_no_ack", {rd_ack, stdp_ack}, 0);
    @(negedge clk);
    kill = 1'b0; rd_req = 1'b0;
    #1;
    chk("kill_init_ready", init_ready, 1);
    chk("kill_init_done", init_done, 0);
    chk("kill_idle_port", mem_en, 0);
    init_load();
    rd(7'd40, 8'd40);

    // Kill right after a read ack: that read still completes
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 7'd7;
    #1;
    chk("kr_ack", rd_ack, 1);
    exp_q.push_back(8'd7);
    @(negedge clk);
    rd_req = 1'b0; kill = 1'b1;
    #1;
    chk("kr_valid", rd_valid, 1);
    @(negedge clk);
    kill = 1'b0;
    #1;
    chk("kr_after", {rd_valid, rd_weight, init_done}, 0);
    chk("kr_init_ready", init_ready, 1);
    init_load();

    // Reset the cycle after a read ack
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 7'd33;
    #1;
    chk("rr_ack", rd_ack, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_req = 1'b0;
    #1;
    chk("rr_rd_valid", rd_valid, 0);
    chk("rr_rd_weight", rd_weight, 0);
    chk("rr_state", {init_ready, init_done}, 2'b10);
    repeat (2) @(negedge clk);

    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/synapse_access_ctrl.md
# synapse_access_ctrl

Single-port access controller for the synapse weight memory (32 words × 32 bits, four 8-bit weights per word). After reset it streams the initial weight table into memory. It then arbitrates between spike-driven weight reads and STDP read-modify-write updates on the one memory port, with starvation protection for STDP. It sits between the neuron/STDP logic and the weight memory macro, which has 1-cycle read latency.

## Interface
- WORDS, 32, weight memory depth in 32-bit words
- STARVE_LIM, 4, count of consecutive cycles an STDP request is denied before it gets priority (≥1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- kill  in  1  synchronous restart: abandon the current operation and return to the init load
- init_valid  in  1  init word present
- init_data  in  32  init word (byte k = weight at byte address 4·word+k)
- init_ready  out  1  controller accepts an init word
- init_done  out  1  table loaded; request arbitration enabled
- rd_req  in  1  weight read request
- rd_addr  in  7  byte address of the weight
- rd_ack  out  1  read accepted this cycle
- rd_valid  out  1  rd_weight valid
- rd_weight  out  8  returned weight
- stdp_req  in  1  STDP update request
- stdp_addr  in  7  byte address of the weight to update
- stdp_delta  in  9  signed weight change (two's complement)
- stdp_ack  out  1  update accepted this cycle
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write when 1, read when 0
- mem_addr  out  5  word address
- mem_wdata  out  32  write word
- mem_rdata  in  32  read word, valid the cycle after a read access

## Operation
- **States:** INIT, IDLE, STDP_WR.
- **Reset / kill:**
  - State goes to INIT and init_cnt goes to 0.
  - init_done=0, rd_valid=0, rd_weight=0, wait counter=0.
  - In the kill cycle, mem_en=0. This suppresses any pending STDP write.
  - If a read was acked in the previous cycle, its rd_valid still fires.
- **INIT:**
  - init_ready=1. Each init_valid∧init_ready cycle writes init_data to word init_cnt (mem_en=1, mem_we=1) and increments init_cnt.
  - The write of word WORDS-1 moves the state to IDLE and sets init_done=1 (registered).
  - rd_req and stdp_req are ignored: no ack.
- **IDLE arbitration, one grant per cycle:**
  - Read wins by default.
  - STDP wins when rd_req=0, or when the wait counter equals STARVE_LIM.
- **Read grant:**
  - rd_ack=1, mem_en=1, mem_we=0, mem_addr=rd_addr[6:2].
  - The next cycle: rd_valid=1 and rd_weight = mem_rdata byte rd_addr[1:0] (byte 0 = bits 7:0).
  - Back-to-back reads are sustained at one per cycle.
- **STDP grant (cycle T):**
  - stdp_ack=1. A read is issued to stdp_addr[6:2]. The address, delta and byte select are latched. State goes to STDP_WR.
- **STDP_WR (cycle T+1):**
  - new = clamp(byte + stdp_delta, 0, 255), computed as a 10-bit signed sum.
  - mem_wdata = mem_rdata with only the selected byte replaced. mem_we=1, to the same word.
  - No acks in this cycle. Return to IDLE.
- **Wait counter:**
  - Increments (saturating at STARVE_LIM) each IDLE cycle with stdp_req=1 and stdp_ack=0.
  - Clears on stdp_ack, and whenever stdp_req=0.
- Requesters hold req/addr/delta stable until ack.

## Timing
- rd_ack, stdp_ack, init_ready and the mem_* outputs are combinational from the state and the requests.
- rd_valid, rd_weight and init_done are registered.
- Read latency: ack at T, rd_valid at T+1.
- STDP occupies the port for T and T+1. A read acked at T+2 to the same word returns the updated weight at T+3.
- A read acked at T+1 is impossible: the port is busy with the STDP write.
- Loading the table takes WORDS accepted cycles. The first ack is possible in the cycle after the last init write.
- Reset values: init_ready=1, all other outputs 0.

## Test plan
- **Init load:** stream 32 words, word i = {4i+3,4i+2,4i+1,4i}. Required: init_done=1 the cycle after the 32nd accept, and 32 writes on mem_addr 0..31. Then read addr 0x45 → rd_weight=0x45 one cycle after rd_ack.
- **Saturation:**
  - Weight at byte 9 = 250, delta +10 → reads back 255.
  - Weight 3, delta −10 (0x1F6) → 0.
  - Weight 100, delta −256 → 0.
  - Neighbouring bytes in the word are unchanged.
- **Collision:** rd_req and stdp_req both high from IDLE with STARVE_LIM=4, continuous reads. Required: reads acked for 4 cycles, then stdp_ack, STDP_WR, then reads resume.
- **Read-after-update:** STDP on addr 20, delta +1, with a read of addr 20 pending. Required: rd_ack no earlier than T+2, and the read returns the old value+1.
- **Kill mid-STDP:** kill asserted during STDP_WR. Required: no write (mem_en=0), state INIT, init_done=0, init_ready=1.
- **Reset mid-read:** rst low the cycle after rd_ack. Required: rd_valid=0, rd_weight=0.
